div8: RTL and testbench

Sequential 8-bit unsigned divider using restoring shift-subtract. It is the inverse counterpart of the team's repeated-addition multiplier and shares that block's operand/start conventions (`A`, `B`, `S`). A start pulse latches the dividend and divisor. After a fixed number of iterations the block returns quotient and remainder with a one-cycle `done` strobe. It sits beside the multiplier in the arithmetic exercise datapath and is driven by the same kind of testbench/controller.

---
 rtl/div8_if.sv | 35 +++
 rtl/div8.sv | 113 +++++++++++
 tb/tb_div8.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/div8_if.sv
// div8_if: operand/result bundle for the sequential divider.
//
// Signals:
//   A, B  - dividend and divisor, driven by the controller.
//   S     - start request, driven by the controller.
//   Q, R  - quotient and remainder, driven by the divider.
//   done  - one-cycle strobe when Q/R/dz are freshly written.
//   busy  - high while the divider is iterating.
//   dz    - divide-by-zero flag belonging to the last result.
//
// Modports:
//   master - the controller side (drives A/B/S, reads results).
//   slave  - the divider side (reads A/B/S, drives results).
interface div8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             S;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             done;
    logic             busy;
    logic             dz;

    modport master (
        output A, B, S,
        input  Q, R, done, busy, dz
    );

    modport slave (
        input  A, B, S,
        output Q, R, done, busy, dz
    );
endinterface

// File: rtl/div8.sv
// div8: sequential unsigned divider using restoring shift-subtract.
//
// A start request in IDLE latches dividend and divisor. One quotient bit is
// produced per clock; after WIDTH iterations the quotient and remainder are
// written to Q/R together with a one-cycle done strobe. A zero divisor is
// answered immediately with Q = all ones, R = dividend and dz = 1.
//
// Ports:
//   clk - single clock, all state changes on the rising edge.
//   rst - asynchronous, active-high reset.
//   bus - div8_if slave modport (A, B, S in; Q, R, done, busy, dz out).
module div8 #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    div8_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH:0]   rem_next;

    // The partial remainder never reaches the divisor, so its top bit is
    // always zero after a restoring step; it is kept only for the compare.
    logic             unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    // One restoring step: bring in the next dividend bit, subtract the
    // divisor if it fits and record whether it did as the quotient bit.
    always_comb begin
        trial    = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        fits     = (trial >= {1'b0, dvs});
        rem_next = fits ? (trial - {1'b0, dvs}) : trial;
    end

    // Control FSM and datapath registers. Results are only written on the
    // final iteration or on a zero-divisor start, so Q/R/dz hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            bus.Q    <= '0;
            bus.R    <= '0;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
            bus.dz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.S) begin
                        if (bus.B != '0) begin
                            dvd      <= bus.A;
                            dvs      <= bus.B;
                            rem      <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= CALC;
                        end else begin
                            // Zero divisor: answer right away, skip CALC.
                            bus.Q    <= '1;
                            bus.R    <= bus.A;
                            bus.dz   <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end

                CALC: begin
                    dvd <= {dvd[WIDTH-2:0], fits};
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        bus.Q    <= {dvd[WIDTH-2:0], fits};
                        bus.R    <= rem_next[WIDTH-1:0];
                        bus.dz   <= 1'b0;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    // Start requests are deliberately ignored here.
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div8.sv
// tb_div8: self-checking bench for div8.
//
// Stimulus tasks issue divisions and push the expected result (computed with
// plain / and %) into a scoreboard queue; an independent monitor pops and
// compares whenever done is seen. Directed sequences cover the latency,
// divide-by-zero, ignored restart, held start and asynchronous reset cases,
// followed by a batch of random operands.
module tb_div8;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_done = 1'b0;

    div8_if #(.WIDTH(WIDTH)) bus();

    div8 #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference behaviour straight from the arithmetic definition.
    function automatic exp_t refModel(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q  = '1;
            e.r  = WIDTH'(a);
            e.dz = 1'b1;
        end else begin
            e.q  = WIDTH'(a / b);
            e.r  = WIDTH'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Idle means neither iterating nor presenting a result.
    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_timeout: got busy=%0b done=%0b expected idle", bus.busy, bus.done);
        end
    endtask

    // Issue one start pulse; operands are scrambled after the accepting edge.
    task automatic applyStimulus(input int a, input int b);
        waitIdle();
        bus.A = WIDTH'(a);
        bus.B = WIDTH'(b);
        bus.S = 1'b1;
        sb.push_back(refModel(a, b));
        @(posedge clk);
        #1;
        bus.S = 1'b0;
        bus.A = WIDTH'($urandom);
        bus.B = WIDTH'($urandom);
    endtask

    // Monitor: compares every done strobe against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (bus.done) begin
                    if (prev_done) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL done_width: got done high 2 cycles expected 1");
                    end
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_done: got done=1 expected 0 (Q=%0d R=%0d)", bus.Q, bus.R);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result_Q", int'(bus.Q), int'(e.q));
                        checkOutput("result_R", int'(bus.R), int'(e.r));
                        checkOutput("result_dz", int'(bus.dz), int'(e.dz));
                        checkOutput("result_busy", int'(bus.busy), 0);
                    end
                end
                prev_done = bus.done;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t held;
        bus.A = '0;
        bus.B = '0;
        bus.S = 1'b0;
        rst   = 1'b1;
        #12;
        checkOutput("reset_Q", int'(bus.Q), 0);
        checkOutput("reset_R", int'(bus.R), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_dz", int'(bus.dz), 0);
        @(negedge clk);
        rst = 1'b0;

        // Latency: busy for WIDTH cycles, done right after.
        applyStimulus(200, 7);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            checkOutput("lat_busy", int'(bus.busy), 1);
            checkOutput("lat_done", int'(bus.done), 0);
        end
        @(negedge clk);
        checkOutput("lat_done_at_w", int'(bus.done), 1);
        @(negedge clk);
        checkOutput("lat_done_fall", int'(bus.done), 0);

        // Boundary operand patterns.
        applyStimulus(255, 1);
        applyStimulus(5, 9);
        applyStimulus(0, 3);

        // Divide by zero: immediate answer, never busy.
        applyStimulus(77, 0);
        @(negedge clk);
        checkOutput("dz_done", int'(bus.done), 1);
        checkOutput("dz_busy", int'(bus.busy), 0);
        @(negedge clk);
        checkOutput("dz_done_fall", int'(bus.done), 0);
        checkOutput("dz_busy_after", int'(bus.busy), 0);

        // A start request during CALC must be ignored.
        applyStimulus(100, 10);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.A = 8'd9;
        bus.B = 8'd3;
        bus.S = 1'b1;
        @(posedge clk);
        #1;
        bus.S = 1'b0;
        waitIdle();
        repeat (12) @(negedge clk);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        waitIdle();
        held  = refModel(50, 6);
        bus.A = 8'd50;
        bus.B = 8'd6;
        bus.S = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(held);
        for (int k = 0; k < 3 * (WIDTH + 2); k++) begin
            @(negedge clk);
            checkOutput("held_done", int'(bus.done), int'((k % (WIDTH + 2)) == WIDTH));
            checkOutput("held_busy", int'(bus.busy), int'((k % (WIDTH + 2)) < WIDTH));
            if (k > WIDTH && !bus.done) begin
                checkOutput("held_Q", int'(bus.Q), int'(held.q));
                checkOutput("held_R", int'(bus.R), int'(held.r));
            end
        end
        bus.S = 1'b0;

        // Asynchronous reset mid-division aborts without a done.
        applyStimulus(200, 7);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #4;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("abort_Q", int'(bus.Q), 0);
        checkOutput("abort_R", int'(bus.R), 0);
        checkOutput("abort_done", int'(bus.done), 0);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_dz", int'(bus.dz), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput("abort_quiet", int'(bus.done | bus.busy), 0);
        end
        applyStimulus(200, 7);

        // Random operands, roughly one in eight with a zero divisor.
        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            applyStimulus(a, b);
        end

        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("sb_pending", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
